// File: rtl/mmio_uart_tx_if.sv
// MMIO register bus between the data-memory crossbar and the UART transmitter.
// Member names follow the responder's port naming (i_* into it, o_* out of it).
interface mmio_uart_tx_if;
   logic [29:0] i_addr;
   logic [31:0] i_data;
   logic        i_wren;
   logic [3:0]  i_mask;
   logic [31:0] o_data;

   modport master (
      output i_addr, i_data, i_wren, i_mask,
      input  o_data
   );

   modport slave (
      input  i_addr, i_data, i_wren, i_mask,
      output o_data
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO plus 8N1 serialiser.
// Define MMIO_UART_PARITY_EN to insert a parity bit (8E1/8O1 via CTRL[1]).
module mmio_uart_tx #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   mmio_uart_tx_if.slave bus,
   output logic          o_tx,
   output logic          o_irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     baud_q, baud_d;
   logic [15:0]     bdiv_q, bdiv_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     div_q, div_d;
   logic            tx_en_q, tx_en_d;
   logic            irq_en_q, irq_en_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            full, empty, busy;
   logic            pop, accept, bit_end;
   logic            wr_tx, wr_st, wr_div, wr_ctl;
   logic            par_odd;
   logic [15:0]     eff_div;
   logic [7:0]      head;
   logic            unused_ok;

`ifdef MMIO_UART_PARITY_EN
   logic            par_q, par_d;
   logic            par_odd_q, par_odd_d;
   assign par_odd = par_odd_q;
`else
   assign par_odd = 1'b0;
`endif

   assign unused_ok = ^bus.i_data[31:16];

   assign full    = (cnt_q == CW'(FIFO_DEPTH));
   assign empty   = (cnt_q == '0);
   assign busy    = (state_q != S_IDLE);
   assign eff_div = (div_q == 16'd0) ? 16'd1 : div_q;
   assign bit_end = (baud_q == bdiv_q - 16'd1);
   assign head    = mem_q[rptr_q];

   assign wr_tx  = bus.i_wren && (bus.i_addr == 30'd0) && bus.i_mask[0];
   assign wr_st  = bus.i_wren && (bus.i_addr == 30'd1) && bus.i_mask[0]
                   && bus.i_data[3];
   assign wr_div = bus.i_wren && (bus.i_addr == 30'd2);
   assign wr_ctl = bus.i_wren && (bus.i_addr == 30'd3) && bus.i_mask[0];

   assign o_tx  = tx_q;
   assign o_irq = irq_en_q && empty && !busy;

   always_comb begin
      bus.o_data = '0;
      case (bus.i_addr)
         30'd1:   bus.o_data = {16'd0, 8'(cnt_q), 4'd0,
                                ovf_q, empty, full, busy};
         30'd2:   bus.o_data = {16'd0, div_q};
         30'd3:   bus.o_data = {29'd0, irq_en_q, par_odd, tx_en_q};
         default: bus.o_data = '0;
      endcase
   end

   // Serialiser; each bit length is latched at its boundary
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 16'd1;
      bdiv_d  = bdiv_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (tx_en_q && !empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               bdiv_d  = eff_div;
               bit_d   = '0;
               state_d = S_START;
`ifdef MMIO_UART_PARITY_EN
               par_d   = ^head;
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_d  = '0;
               bdiv_d  = eff_div;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               bdiv_d = eff_div;
               if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                  tx_d    = par_q ^ par_odd_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               baud_d  = '0;
               bdiv_d  = eff_div;
               tx_d    = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            baud_d  = '0;
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping and register writes
   always_comb begin
      accept   = wr_tx && (!full || pop);
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      div_d    = div_q;
      tx_en_d  = tx_en_q;
      irq_en_d = irq_en_q;
`ifdef MMIO_UART_PARITY_EN
      par_odd_d = par_odd_q;
`endif
      if (accept) wptr_d = wptr_q + AW'(1);
      if (pop)    rptr_d = rptr_q + AW'(1);
      if (accept && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !accept) cnt_d = cnt_q - CW'(1);
      if (wr_st)             ovf_d = 1'b0;
      if (wr_tx && !accept)  ovf_d = 1'b1;
      if (wr_div && bus.i_mask[0]) div_d[7:0]  = bus.i_data[7:0];
      if (wr_div && bus.i_mask[1]) div_d[15:8] = bus.i_data[15:8];
      if (wr_ctl) begin
         tx_en_d  = bus.i_data[0];
         irq_en_d = bus.i_data[2];
`ifdef MMIO_UART_PARITY_EN
         par_odd_d = bus.i_data[1];
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) mem_q[wptr_q] <= bus.i_data[7:0];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bdiv_q   <= 16'd1;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DEFAULT_DIV;
         tx_en_q  <= 1'b0;
         irq_en_q <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
         par_q     <= 1'b0;
         par_odd_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bdiv_q   <= bdiv_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         div_q    <= div_d;
         tx_en_q  <= tx_en_d;
         irq_en_q <= irq_en_d;
`ifdef MMIO_UART_PARITY_EN
         par_q     <= par_d;
         par_odd_q <= par_odd_d;
`endif
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register vector table plus frame,
// FIFO overflow, pop-cycle push, parity and mid-frame reset sequences.
module tb_mmio_uart_tx;

`ifdef MMIO_UART_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic i_clk = 1'b0;
   logic i_rst_n;
   logic o_tx, o_irq;
   int   total = 0;
   int   bad = 0;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .FIFO_DEPTH  (8),
      .DEFAULT_DIV (16'd868)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus.slave),
      .o_tx    (o_tx),
      .o_irq   (o_irq)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          we;
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [29:0] raddr;
      logic [31:0] exp;
      bit          irq;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; the write lands on the next posedge.
   task automatic wr(input logic [29:0] a, input logic [31:0] d,
                     input logic [3:0] m);
      bus.i_addr = a;
      bus.i_data = d;
      bus.i_mask = m;
      bus.i_wren = 1'b1;
      @(negedge i_clk);
      bus.i_wren = 1'b0;
      bus.i_mask = 4'h0;
   endtask

   task automatic rd(input logic [29:0] a, output logic [31:0] d);
      bus.i_addr = a;
      #1;
      d = bus.o_data;
   endtask

   task automatic check_frame(input logic [7:0] b, input int div,
                              input bit par_en, input bit odd);
      logic [10:0] bits;
      logic [31:0] d;
      int n;
      bits = '0;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
      if (par_en) begin
         bits[9]  = (^b) ^ odd;
         bits[10] = 1'b1;
         n = 11;
      end else begin
         bits[9] = 1'b1;
         n = 10;
      end
      chk("idle_before_start", {31'd0, o_tx}, 32'd1);
      for (int i = 0; i < n * div; i++) begin
         @(negedge i_clk);
         chk($sformatf("txbit[%0d] cyc %0d", i / div, i),
             {31'd0, o_tx}, {31'd0, bits[i/div]});
      end
      @(negedge i_clk);
      rd(30'd1, d);
      chk("busy_after_frame", {31'd0, d[0]}, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int n;

      vt[0]  = '{0, 30'd0, 32'h0,        4'h0, 30'd1, 32'h4,   0};
      vt[1]  = '{0, 30'd0, 32'h0,        4'h0, 30'd2, 32'h364, 0};
      vt[2]  = '{0, 30'd0, 32'h0,        4'h0, 30'd3, 32'h0,   0};
      vt[3]  = '{1, 30'd2, 32'h1234,     4'h1, 30'd2, 32'h334, 0};
      vt[4]  = '{1, 30'd2, 32'hFFFF5678, 4'h2, 30'd2, 32'h5634, 0};
      vt[5]  = '{1, 30'd2, 32'hABCD,     4'h0, 30'd2, 32'h5634, 0};
      vt[6]  = '{1, 30'd3, 32'hFD,       4'h1, 30'd3, 32'h5,   1};
      vt[7]  = '{1, 30'd3, 32'h07,       4'hE, 30'd3, 32'h5,   1};
      vt[8]  = '{1, 30'd3, 32'h02,       4'h1, 30'd3,
                 PAR ? 32'h2 : 32'h0, 0};
      vt[9]  = '{1, 30'd3, 32'h0,        4'h1, 30'd3, 32'h0,   0};
      vt[10] = '{1, 30'd5, 32'h1234,     4'hF, 30'd5, 32'h0,   0};
      vt[11] = '{1, 30'd0, 32'h41,       4'h0, 30'd1, 32'h4,   0};
      vt[12] = '{1, 30'd1, 32'h08,       4'hF, 30'd1, 32'h4,   0};
      vt[13] = '{1, 30'd2, 32'h0,        4'h3, 30'd2, 32'h0,   0};
      vt[14] = '{0, 30'd0, 32'h0,        4'h0, 30'd0, 32'h0,   0};

      bus.i_addr = '0;
      bus.i_data = '0;
      bus.i_mask = '0;
      bus.i_wren = 1'b0;
      i_rst_n = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("reset_tx", {31'd0, o_tx}, 32'd1);
      chk("reset_irq", {31'd0, o_irq}, 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      for (int i = 0; i < 15; i++) begin
         if (vt[i].we) wr(vt[i].waddr, vt[i].wdata, vt[i].wmask);
         rd(vt[i].raddr, d);
         chk($sformatf("vec%0d_rd", i), d, vt[i].exp);
         chk($sformatf("vec%0d_irq", i), {31'd0, o_irq},
             {31'd0, vt[i].irq});
         @(negedge i_clk);
      end

      // Frame 0xA5 at 4 cycles per bit
      wr(30'd2, 32'd4, 4'h3);
      wr(30'd3, 32'd1, 4'h1);
      wr(30'd0, 32'hA5, 4'h1);
      check_frame(8'hA5, 4, PAR, 1'b0);

      // DIVISOR=0 acts as 1
      wr(30'd2, 32'd0, 4'h3);
      wr(30'd0, 32'h3C, 4'h1);
      check_frame(8'h3C, 1, PAR, 1'b0);

`ifdef MMIO_UART_PARITY_EN
      wr(30'd2, 32'd2, 4'h3);
      wr(30'd3, 32'd1, 4'h1);
      wr(30'd0, 32'h07, 4'h1);
      check_frame(8'h07, 2, 1'b1, 1'b0);
      wr(30'd3, 32'd3, 4'h1);
      wr(30'd0, 32'h07, 4'h1);
      check_frame(8'h07, 2, 1'b1, 1'b1);
`endif

      // Overflow: 9 writes into an 8-deep FIFO with tx disabled
      wr(30'd3, 32'd0, 4'h1);
      wr(30'd2, 32'd1, 4'h3);
      for (int i = 0; i < 9; i++) wr(30'd0, 32'h10 + i, 4'h1);
      rd(30'd1, d);
      chk("ovf_status", d, 32'h80A);
      wr(30'd1, 32'h8, 4'h1);
      rd(30'd1, d);
      chk("ovf_cleared", d, 32'h802);

      // Push on the exact pop cycle while full
      wr(30'd3, 32'd1, 4'h1);
      wr(30'd0, 32'h55, 4'h1);
      rd(30'd1, d);
      chk("push_on_pop", d, 32'h803);

      n = 0;
      rd(30'd1, d);
      while (d != 32'h4 && n < 400) begin
         @(negedge i_clk);
         rd(30'd1, d);
         n++;
      end
      chk("drain_status", d, 32'h4);

      // Reset in the middle of the data bits
      wr(30'd2, 32'd4, 4'h3);
      @(negedge i_clk);
      wr(30'd0, 32'h00, 4'h1);
      repeat (10) @(negedge i_clk);
      chk("mid_frame_low", {31'd0, o_tx}, 32'd0);
      i_rst_n = 1'b0;
      #1;
      chk("rst_tx_high", {31'd0, o_tx}, 32'd1);
      rd(30'd1, d);
      chk("rst_status", d, 32'h4);
      rd(30'd2, d);
      chk("rst_div", d, 32'd868);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      wr(30'd2, 32'd1, 4'h3);
      wr(30'd3, 32'd1, 4'h1);
      repeat (3) @(negedge i_clk);
      chk("post_rst_idle_tx", {31'd0, o_tx}, 32'd1);
      rd(30'd1, d);
      chk("post_rst_status", d, 32'h4);
      wr(30'd0, 32'h5A, 4'h1);
      check_frame(8'h5A, 1, PAR, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
